// File: rtl/bpmc_pkg.sv
// Shared types and defaults for the BPMC pulse-train blocks.
// Holds the sequencer state encoding and the default field widths.
package bpmc_pkg;

  localparam int BPMC_CNT_W = 16;
  localparam int BPMC_REP_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POS  = 3'd1,
    DEAD = 3'd2,
    NEG  = 3'd3,
    GAP  = 3'd4
  } bpmc_state_e;

endpackage

// File: rtl/bpmc_edge_det.sv
// Registered rising-edge detector with asynchronous reset.
// The rise flag is valid in the same cycle the input is first seen high.
module bpmc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/bpmc_pulse_gen.sv
// Bipolar pulse-train generator: POS, DEAD, NEG, GAP phases repeated per trigger.
// Optional Abort input is enabled by defining BPMC_ABORT_EN.
module bpmc_pulse_gen
  import bpmc_pkg::*;
#(
  parameter int CNT_W = BPMC_CNT_W,
  parameter int REP_W = BPMC_REP_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Trig,
  input  logic [CNT_W-1:0] Cfg_PosWidth,
  input  logic [CNT_W-1:0] Cfg_DeadTime,
  input  logic [CNT_W-1:0] Cfg_NegWidth,
  input  logic [CNT_W-1:0] Cfg_Gap,
  input  logic [REP_W-1:0] Cfg_Repeat,
`ifdef BPMC_ABORT_EN
  input  logic             Abort,
`endif
  output logic             Dout_P,
  output logic             Dout_N,
  output logic             Busy,
  output logic             Done
);

  bpmc_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] pos_q, dead_q, neg_q, gap_q;
  logic             trig_rise;
  logic             accept;
  logic             rep_end;
  logic             done_d;

  bpmc_edge_det u_trig_edge (
    .clk  (Clock),
    .rst  (Reset),
    .sig  (Trig),
    .rise (trig_rise)
  );

  assign accept = (state_q == IDLE) && trig_rise && (Cfg_Repeat != '0) &&
                  ((Cfg_PosWidth | Cfg_NegWidth) != '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      Dout_P  <= 1'b0;
      Dout_N  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      Dout_P  <= (state_d == POS);
      Dout_N  <= (state_d == NEG);
      Busy    <= (state_d != IDLE);
      Done    <= done_d;
    end
  end

  // Configuration is captured only at acceptance so mid-sequence changes are ignored.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pos_q  <= '0;
      dead_q <= '0;
      neg_q  <= '0;
      gap_q  <= '0;
    end else if (accept) begin
      pos_q  <= Cfg_PosWidth;
      dead_q <= Cfg_DeadTime;
      neg_q  <= Cfg_NegWidth;
      gap_q  <= Cfg_Gap;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    rep_end = 1'b0;
    done_d  = 1'b0;

    if (state_q == IDLE) begin
      if (accept) begin
        rep_d = Cfg_Repeat;
        if (Cfg_PosWidth != '0) begin
          state_d = POS;
          cnt_d   = Cfg_PosWidth - CNT_W'(1);
        end else begin
          state_d = NEG;
          cnt_d   = Cfg_NegWidth - CNT_W'(1);
        end
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      // Phase expired: jump straight to the next phase with a nonzero length.
      case (state_q)
        POS: begin
          if ((dead_q != '0) && (neg_q != '0)) begin
            state_d = DEAD;
            cnt_d   = dead_q - CNT_W'(1);
          end else if (neg_q != '0) begin
            state_d = NEG;
            cnt_d   = neg_q - CNT_W'(1);
          end else begin
            rep_end = 1'b1;
          end
        end
        DEAD: begin
          state_d = NEG;
          cnt_d   = neg_q - CNT_W'(1);
        end
        NEG: begin
          rep_end = 1'b1;
        end
        GAP: begin
          if (pos_q != '0) begin
            state_d = POS;
            cnt_d   = pos_q - CNT_W'(1);
          end else begin
            state_d = NEG;
            cnt_d   = neg_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // The gap is only inserted between repetitions, never after the last one.
      if (rep_end) begin
        if (rep_q == REP_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          rep_d   = '0;
          done_d  = 1'b1;
        end else begin
          rep_d = rep_q - REP_W'(1);
          if (gap_q != '0) begin
            state_d = GAP;
            cnt_d   = gap_q - CNT_W'(1);
          end else if (pos_q != '0) begin
            state_d = POS;
            cnt_d   = pos_q - CNT_W'(1);
          end else begin
            state_d = NEG;
            cnt_d   = neg_q - CNT_W'(1);
          end
        end
      end
    end

`ifdef BPMC_ABORT_EN
    if (Abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      rep_d   = '0;
      done_d  = 1'b1;
    end
`endif
  end

endmodule
